// File: rtl/riscv_pkg.sv
// Shared RV64 encoding constants: micro-op codes, major opcodes, funct fields
// and the FIFO entry layout. Also imported by the decode stage.
package riscv_pkg;

  localparam int ALU_W = 6;
  localparam int REG_W = 5;

  // Micro-op alu_control codes
  localparam logic [5:0] ALU_ADDI  = 6'd1,  ALU_SLTI  = 6'd2,  ALU_SLTIU = 6'd3,
                         ALU_XORI  = 6'd4,  ALU_ORI   = 6'd5,  ALU_ANDI  = 6'd6,
                         ALU_SLLI  = 6'd7,  ALU_SRLI  = 6'd8,  ALU_SRAI  = 6'd9;
  localparam logic [5:0] ALU_ADD   = 6'd12, ALU_SUB   = 6'd13, ALU_SLL   = 6'd14,
                         ALU_SLT   = 6'd15, ALU_SLTU  = 6'd16, ALU_XOR   = 6'd17,
                         ALU_SRL   = 6'd18, ALU_SRA   = 6'd19, ALU_OR    = 6'd20,
                         ALU_AND   = 6'd21;
  localparam logic [5:0] ALU_ADDIW = 6'd22, ALU_SLLIW = 6'd23, ALU_SRLIW = 6'd24,
                         ALU_SRAIW = 6'd25;
  localparam logic [5:0] ALU_ADDW  = 6'd26, ALU_SUBW  = 6'd27, ALU_SLLW  = 6'd28,
                         ALU_SRLW  = 6'd29, ALU_SRAW  = 6'd30;
  localparam logic [5:0] ALU_MUL   = 6'd31, ALU_MULH  = 6'd32, ALU_MULHSU = 6'd33,
                         ALU_MULHU = 6'd34, ALU_DIV   = 6'd35, ALU_DIVU  = 6'd36,
                         ALU_REM   = 6'd37, ALU_REMU  = 6'd38;
  localparam logic [5:0] ALU_MULW  = 6'd39, ALU_DIVW  = 6'd40, ALU_DIVUW = 6'd41,
                         ALU_REMW  = 6'd42, ALU_REMUW = 6'd43;

  // Major opcodes
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  // funct3 values (base integer and M extension share the field)
  localparam logic [2:0] F3_ADD = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010,
                         F3_SLTU = 3'b011, F3_XOR = 3'b100, F3_SR = 3'b101,
                         F3_OR = 3'b110, F3_AND = 3'b111;
  localparam logic [2:0] F3_MUL = 3'b000, F3_MULH = 3'b001, F3_MULHSU = 3'b010,
                         F3_MULHU = 3'b011, F3_DIV = 3'b100, F3_DIVU = 3'b101,
                         F3_REM = 3'b110, F3_REMU = 3'b111;

  // funct7 values; the 64-bit shift funct6 is funct7[6:1]
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // Word stored in place of a rejected micro-op (addi x0,x0,0)
  localparam logic [31:0] INS_NOP = 32'h00000013;

  typedef enum logic [2:0] {
    CLS_BAD,
    CLS_I,
    CLS_SH64,
    CLS_SHW,
    CLS_R
  } ins_class_e;

  typedef struct packed {
    logic        err;
    logic [31:0] ins;
  } fifo_entry_t;

endpackage

// File: rtl/encode1_if.sv
// Micro-op request channel and encoded instruction stream of encode1.
interface encode1_if #(
  parameter int BUS_DATA_WIDTH = 64
);
  import riscv_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [ALU_W-1:0]          in_alu_control;
  logic [REG_W-1:0]          in_addressA;
  logic [REG_W-1:0]          in_addressB;
  logic [REG_W-1:0]          in_addressC;
  logic [BUS_DATA_WIDTH-1:0] in_imm;
  logic                      in_muxB_control;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_ins;
  logic                      out_err;

  modport master (
    output in_valid, in_alu_control, in_addressA, in_addressB, in_addressC,
           in_imm, in_muxB_control, out_ready,
    input  in_ready, out_valid, out_ins, out_err
  );

  modport slave (
    input  in_valid, in_alu_control, in_addressA, in_addressB, in_addressC,
           in_imm, in_muxB_control, out_ready,
    output in_ready, out_valid, out_ins, out_err
  );

endinterface

// File: rtl/ins_encode.sv
// Purely combinational RV64 encoder: one micro-op in, one 32-bit word plus
// an error flag out. Errors replace the word with a NOP.
module ins_encode
  import riscv_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic [ALU_W-1:0]          alu_control,
  input  logic [REG_W-1:0]          address_a,
  input  logic [REG_W-1:0]          address_b,
  input  logic [REG_W-1:0]          address_c,
  input  logic [BUS_DATA_WIDTH-1:0] imm,
  input  logic                      muxb_control,
  output logic [31:0]               ins,
  output logic                      err
);

  ins_class_e cls;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       imm12_ok;
  logic       sh64_ok;
  logic       shw_ok;
  logic [31:0] word;
  logic        bad;

  // Operand range checks: 12-bit signed immediate, 6-bit and 5-bit shamt
  assign imm12_ok = (&imm[BUS_DATA_WIDTH-1:11]) | ~(|imm[BUS_DATA_WIDTH-1:11]);
  assign sh64_ok  = ~(|imm[BUS_DATA_WIDTH-1:6]);
  assign shw_ok   = ~(|imm[BUS_DATA_WIDTH-1:5]);

  // Classify the code and select opcode/funct fields
  always_comb begin
    cls = CLS_BAD;
    opc = '0;
    f3  = '0;
    f7  = F7_BASE;
    case (alu_control)
      ALU_ADDI:   begin cls = CLS_I;    opc = OPC_OP_IMM;    f3 = F3_ADD;  end
      ALU_SLTI:   begin cls = CLS_I;    opc = OPC_OP_IMM;    f3 = F3_SLT;  end
      ALU_SLTIU:  begin cls = CLS_I;    opc = OPC_OP_IMM;    f3 = F3_SLTU; end
      ALU_XORI:   begin cls = CLS_I;    opc = OPC_OP_IMM;    f3 = F3_XOR;  end
      ALU_ORI:    begin cls = CLS_I;    opc = OPC_OP_IMM;    f3 = F3_OR;   end
      ALU_ANDI:   begin cls = CLS_I;    opc = OPC_OP_IMM;    f3 = F3_AND;  end
      ALU_SLLI:   begin cls = CLS_SH64; opc = OPC_OP_IMM;    f3 = F3_SLL;  end
      ALU_SRLI:   begin cls = CLS_SH64; opc = OPC_OP_IMM;    f3 = F3_SR;   end
      ALU_SRAI:   begin cls = CLS_SH64; opc = OPC_OP_IMM;    f3 = F3_SR;   f7 = F7_ALT; end
      ALU_ADD:    begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_ADD;  end
      ALU_SUB:    begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_ADD;  f7 = F7_ALT; end
      ALU_SLL:    begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_SLL;  end
      ALU_SLT:    begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_SLT;  end
      ALU_SLTU:   begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_SLTU; end
      ALU_XOR:    begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_XOR;  end
      ALU_SRL:    begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_SR;   end
      ALU_SRA:    begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_SR;   f7 = F7_ALT; end
      ALU_OR:     begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_OR;   end
      ALU_AND:    begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_AND;  end
      ALU_ADDIW:  begin cls = CLS_I;    opc = OPC_OP_IMM_32; f3 = F3_ADD;  end
      ALU_SLLIW:  begin cls = CLS_SHW;  opc = OPC_OP_IMM_32; f3 = F3_SLL;  end
      ALU_SRLIW:  begin cls = CLS_SHW;  opc = OPC_OP_IMM_32; f3 = F3_SR;   end
      ALU_SRAIW:  begin cls = CLS_SHW;  opc = OPC_OP_IMM_32; f3 = F3_SR;   f7 = F7_ALT; end
      ALU_ADDW:   begin cls = CLS_R;    opc = OPC_OP_32;     f3 = F3_ADD;  end
      ALU_SUBW:   begin cls = CLS_R;    opc = OPC_OP_32;     f3 = F3_ADD;  f7 = F7_ALT; end
      ALU_SLLW:   begin cls = CLS_R;    opc = OPC_OP_32;     f3 = F3_SLL;  end
      ALU_SRLW:   begin cls = CLS_R;    opc = OPC_OP_32;     f3 = F3_SR;   end
      ALU_SRAW:   begin cls = CLS_R;    opc = OPC_OP_32;     f3 = F3_SR;   f7 = F7_ALT; end
      ALU_MUL:    begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_MUL;    f7 = F7_MULDIV; end
      ALU_MULH:   begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_MULH;   f7 = F7_MULDIV; end
      ALU_MULHSU: begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_MULHSU; f7 = F7_MULDIV; end
      ALU_MULHU:  begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_MULHU;  f7 = F7_MULDIV; end
      ALU_DIV:    begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_DIV;    f7 = F7_MULDIV; end
      ALU_DIVU:   begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_DIVU;   f7 = F7_MULDIV; end
      ALU_REM:    begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_REM;    f7 = F7_MULDIV; end
      ALU_REMU:   begin cls = CLS_R;    opc = OPC_OP;        f3 = F3_REMU;   f7 = F7_MULDIV; end
      ALU_MULW:   begin cls = CLS_R;    opc = OPC_OP_32;     f3 = F3_MUL;    f7 = F7_MULDIV; end
      ALU_DIVW:   begin cls = CLS_R;    opc = OPC_OP_32;     f3 = F3_DIV;    f7 = F7_MULDIV; end
      ALU_DIVUW:  begin cls = CLS_R;    opc = OPC_OP_32;     f3 = F3_DIVU;   f7 = F7_MULDIV; end
      ALU_REMW:   begin cls = CLS_R;    opc = OPC_OP_32;     f3 = F3_REM;    f7 = F7_MULDIV; end
      ALU_REMUW:  begin cls = CLS_R;    opc = OPC_OP_32;     f3 = F3_REMU;   f7 = F7_MULDIV; end
      default:    cls = CLS_BAD;
    endcase
  end

  // Assemble the word for the class and validate operand form and range
  always_comb begin
    word = '0;
    bad  = 1'b1;
    case (cls)
      CLS_I: begin
        word = {imm[11:0], address_a, f3, address_c, opc};
        bad  = ~muxb_control | ~imm12_ok;
      end
      CLS_SH64: begin
        word = {f7[6:1], imm[5:0], address_a, f3, address_c, opc};
        bad  = ~muxb_control | ~sh64_ok;
      end
      CLS_SHW: begin
        word = {f7, imm[4:0], address_a, f3, address_c, opc};
        bad  = ~muxb_control | ~shw_ok;
      end
      CLS_R: begin
        word = {f7, address_b, address_a, f3, address_c, opc};
        bad  = muxb_control;
      end
      default: begin
        word = '0;
        bad  = 1'b1;
      end
    endcase
    err = bad;
    ins = bad ? INS_NOP : word;
  end

endmodule

// File: rtl/encode1.sv
// Micro-op to RV64 instruction encoder with a DEPTH-entry output FIFO and a
// saturating count of rejected micro-ops.
module encode1
  import riscv_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int DEPTH          = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  encode1_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   err_count_q, err_count_d;
  fifo_entry_t   mem_q [DEPTH];
  fifo_entry_t   wr_entry_d;

  logic [31:0] enc_ins;
  logic        enc_err;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;

  ins_encode #(
    .BUS_DATA_WIDTH(BUS_DATA_WIDTH)
  ) u_ins_encode (
    .alu_control (bus.in_alu_control),
    .address_a   (bus.in_addressA),
    .address_b   (bus.in_addressB),
    .address_c   (bus.in_addressC),
    .imm         (bus.in_imm),
    .muxb_control(bus.in_muxB_control),
    .ins         (enc_ins),
    .err         (enc_err)
  );

  assign full  = (count_q == FULL);
  assign empty = (count_q == '0);

  // in_ready is held low for the whole reset assertion, not just after it
  assign bus.in_ready  = rst_n & ~full;
  assign bus.out_valid = ~empty;
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  // Storage is not reset, so the head is masked to zero while the FIFO is empty
  assign bus.out_ins = empty ? '0 : mem_q[rd_ptr_q].ins;
  assign bus.out_err = ~empty & mem_q[rd_ptr_q].err;

  // Next-state for pointers, occupancy and the saturating error counter
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    err_count_d = err_count_q;
    wr_entry_d  = '{err: enc_err, ins: enc_ins};
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push && enc_err && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 1'b1;
  end

  // Control state, cleared asynchronously; reset drops every queued entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      err_count_q <= err_count_d;
    end
  end

  // FIFO storage, written at the accepting edge
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry_d;
  end

endmodule

// File: tb/tb_encode1.sv
// Bench for encode1: fixed vectors, FIFO full/back-pressure, random traffic
// against a reference model, and reset while entries are queued.
`timescale 1ns/1ps
module tb_encode1;

  localparam int W     = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  encode1_if #(.BUS_DATA_WIDTH(W)) bus();

  encode1 #(.BUS_DATA_WIDTH(W), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [5:0]  code;
    logic [4:0]  a, b, c;
    logic [63:0] imm;
    logic        muxb;
  } req_t;

  typedef struct {
    req_t        req;
    logic [31:0] ins;
    logic        err;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] sb_q[$];
  int exp_errcnt = 0;

  // funct3 lookup strings, 3 bits per entry, entry 0 in the low bits
  localparam logic [17:0] I_F3  = {3'd7, 3'd6, 3'd4, 3'd3, 3'd2, 3'd0};
  localparam logic [29:0] R_F3  = {3'd7, 3'd6, 3'd5, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
  localparam logic [14:0] W_F3  = {3'd5, 3'd5, 3'd1, 3'd0, 3'd0};
  localparam logic [14:0] MW_F3 = {3'd7, 3'd6, 3'd5, 3'd4, 3'd0};

  function automatic req_t mk(int code, int a, int b, int c, logic [63:0] imm, logic muxb);
    req_t r;
    r.code = 6'(code); r.a = 5'(a); r.b = 5'(b); r.c = 5'(c); r.imm = imm; r.muxb = muxb;
    return r;
  endfunction

  function automatic vec_t mkv(req_t r, logic [31:0] ins, logic err);
    vec_t v;
    v.req = r; v.ins = ins; v.err = err;
    return v;
  endfunction

  function automatic bit is_reg_form(int k);
    return (k >= 12 && k <= 21) || (k >= 26 && k <= 43);
  endfunction

  // Reference encoder: returns {err, word}. fmt 0=I, 1=64-bit shamt, 2=32-bit shamt, 3=R
  function automatic logic [32:0] ref_encode(req_t r);
    int k = int'(r.code);
    int fmt = -1;
    logic [6:0] opc = 7'h00;
    logic [2:0] f3 = 3'd0;
    logic [6:0] f7 = 7'h00;
    longint s = $signed(r.imm);
    bit ok;
    logic [31:0] w = 32'h0;
    if (k >= 1 && k <= 6) begin fmt = 0; opc = 7'h13; f3 = I_F3[3*(k-1) +: 3]; end
    else if (k >= 7 && k <= 9) begin
      fmt = 1; opc = 7'h13; f3 = (k == 7) ? 3'd1 : 3'd5; f7 = (k == 9) ? 7'h20 : 7'h00;
    end
    else if (k >= 12 && k <= 21) begin
      fmt = 3; opc = 7'h33; f3 = R_F3[3*(k-12) +: 3]; f7 = (k == 13 || k == 19) ? 7'h20 : 7'h00;
    end
    else if (k == 22) begin fmt = 0; opc = 7'h1B; f3 = 3'd0; end
    else if (k >= 23 && k <= 25) begin
      fmt = 2; opc = 7'h1B; f3 = (k == 23) ? 3'd1 : 3'd5; f7 = (k == 25) ? 7'h20 : 7'h00;
    end
    else if (k >= 26 && k <= 30) begin
      fmt = 3; opc = 7'h3B; f3 = W_F3[3*(k-26) +: 3]; f7 = (k == 27 || k == 30) ? 7'h20 : 7'h00;
    end
    else if (k >= 31 && k <= 38) begin fmt = 3; opc = 7'h33; f3 = 3'(k - 31); f7 = 7'h01; end
    else if (k >= 39 && k <= 43) begin fmt = 3; opc = 7'h3B; f3 = MW_F3[3*(k-39) +: 3]; f7 = 7'h01; end
    case (fmt)
      0: begin ok = r.muxb && s >= -2048 && s <= 2047; w = {r.imm[11:0], r.a, f3, r.c, opc}; end
      1: begin ok = r.muxb && r.imm < 64; w = {f7[6:1], r.imm[5:0], r.a, f3, r.c, opc}; end
      2: begin ok = r.muxb && r.imm < 32; w = {f7, r.imm[4:0], r.a, f3, r.c, opc}; end
      3: begin ok = !r.muxb; w = {f7, r.b, r.a, f3, r.c, opc}; end
      default: ok = 0;
    endcase
    return ok ? {1'b0, w} : {1'b1, 32'h00000013};
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int k = ($urandom_range(0, 99) < 90) ? int'($urandom_range(1, 43)) : int'($urandom_range(0, 63));
    r.code = 6'(k);
    r.a = 5'($urandom); r.b = 5'($urandom); r.c = 5'($urandom);
    case ($urandom_range(0, 3))
      0: r.imm = 64'($urandom_range(0, 70));
      1: r.imm = -64'($urandom_range(1, 2100));
      2: r.imm = {$urandom, $urandom};
      default: r.imm = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(2040, 2060))
                                                   : 64'($urandom_range(28, 68));
    endcase
    r.muxb = is_reg_form(k) ? 1'b0 : 1'b1;
    if ($urandom_range(0, 9) == 0) r.muxb = ~r.muxb;
    return r;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic drive(req_t r, logic v, logic rdy);
    bus.in_valid        = v;
    bus.out_ready       = rdy;
    bus.in_alu_control  = r.code;
    bus.in_addressA     = r.a;
    bus.in_addressB     = r.b;
    bus.in_addressC     = r.c;
    bus.in_imm          = r.imm;
    bus.in_muxB_control = r.muxb;
  endtask

  // One cycle of streaming traffic: check state at the falling edge, then
  // drive the next request and advance the scoreboard for the coming edge.
  task automatic step(logic v, logic rdy, req_t r);
    bit can_push;
    logic [32:0] e;
    @(negedge clk);
    check("out_valid", bus.out_valid, sb_q.size() != 0);
    check("in_ready", bus.in_ready, sb_q.size() != DEPTH);
    check("count", dut.count_q, sb_q.size());
    if (sb_q.size() != 0) begin
      check("out_ins", bus.out_ins, sb_q[0][31:0]);
      check("out_err", bus.out_err, sb_q[0][32]);
    end
    check("err_count", dut.err_count_q, exp_errcnt);
    drive(r, v, rdy);
    can_push = (sb_q.size() != DEPTH);
    if (rdy && sb_q.size() != 0) void'(sb_q.pop_front());
    if (v && can_push) begin
      e = ref_encode(r);
      sb_q.push_back(e);
      if (e[32] && exp_errcnt != 65535) exp_errcnt++;
    end
  endtask

  vec_t tbl[$];
  req_t idle;

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout, required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int running;
    idle = mk(0, 0, 0, 0, 64'h0, 1'b0);
    rst_n = 1'b0;
    drive(idle, 1'b0, 1'b0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst in_ready", bus.in_ready, 1'b0);
    check("rst out_ins", bus.out_ins, 32'h0);
    check("rst out_err", bus.out_err, 1'b0);
    check("rst err_count", dut.err_count_q, 16'h0);
    rst_n = 1'b1;
    #1 check("in_ready after release", bus.in_ready, 1'b1);

    // Fixed vectors with hand-derived expected words
    tbl.push_back(mkv(mk(1, 6, 0, 5, 64'hFFFF_FFFF_FFFF_FFFF, 1), 32'hFFF30293, 0));
    tbl.push_back(mkv(mk(13, 2, 3, 1, 64'h0, 0), 32'h403100B3, 0));
    tbl.push_back(mkv(mk(39, 8, 9, 7, 64'h0, 0), 32'h029403BB, 0));
    tbl.push_back(mkv(mk(9, 10, 0, 10, 64'd63, 1), 32'h43F55513, 0));
    tbl.push_back(mkv(mk(9, 10, 0, 10, 64'd64, 1), 32'h00000013, 1));
    tbl.push_back(mkv(mk(0, 1, 2, 3, 64'h0, 0), 32'h00000013, 1));
    tbl.push_back(mkv(mk(10, 1, 2, 3, 64'h0, 1), 32'h00000013, 1));
    tbl.push_back(mkv(mk(44, 1, 2, 3, 64'h0, 0), 32'h00000013, 1));
    tbl.push_back(mkv(mk(12, 1, 2, 3, 64'h0, 1), 32'h00000013, 1));
    tbl.push_back(mkv(mk(1, 1, 0, 2, 64'd2047, 1), 32'h7FF08113, 0));
    tbl.push_back(mkv(mk(1, 1, 0, 2, 64'd2048, 1), 32'h00000013, 1));
    tbl.push_back(mkv(mk(1, 1, 0, 2, 64'hFFFF_FFFF_FFFF_F800, 1), 32'h80008113, 0));
    tbl.push_back(mkv(mk(23, 4, 0, 3, 64'd31, 1), 32'h01F2119B, 0));
    tbl.push_back(mkv(mk(23, 4, 0, 3, 64'd32, 1), 32'h00000013, 1));
    tbl.push_back(mkv(mk(7, 1, 0, 1, 64'd32, 1), 32'h02009093, 0));
    tbl.push_back(mkv(mk(38, 6, 7, 5, 64'h0, 0), 32'h027372B3, 0));
    tbl.push_back(mkv(mk(30, 2, 3, 1, 64'h0, 0), 32'h403150BB, 0));
    tbl.push_back(mkv(mk(1, 6, 0, 5, 64'd5, 0), 32'h00000013, 1));

    running = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].req, 1'b1, 1'b1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      running += int'(tbl[i].err);
      check($sformatf("vec%0d out_valid", i), bus.out_valid, 1'b1);
      check($sformatf("vec%0d out_ins", i), bus.out_ins, tbl[i].ins);
      check($sformatf("vec%0d out_err", i), bus.out_err, tbl[i].err);
      check($sformatf("vec%0d err_count", i), dut.err_count_q, running);
    end
    exp_errcnt = running;

    // Back-pressure: five offers with out_ready low, then drain while offering
    for (int k = 0; k < 5; k++) step(1'b1, 1'b0, mk(1, k + 1, 0, k + 10, 64'(k * 10), 1));
    @(negedge clk);
    check("full in_ready", bus.in_ready, 1'b0);
    check("full count", dut.count_q, DEPTH);
    step(1'b1, 1'b1, mk(1, 5, 0, 14, 64'd40, 1));
    step(1'b1, 1'b1, mk(1, 5, 0, 14, 64'd40, 1));
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, idle);

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), rand_req());
    for (int k = 0; k < 6; k++) step(1'b0, 1'b1, idle);

    // Reset with three entries queued
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, mk(9, k, 0, k, 64'd99, 1));
    @(negedge clk);
    drive(idle, 1'b0, 1'b0);
    check("pre-reset count", dut.count_q, 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid-rst out_valid", bus.out_valid, 1'b0);
    check("mid-rst in_ready", bus.in_ready, 1'b0);
    check("mid-rst out_ins", bus.out_ins, 32'h0);
    check("mid-rst err_count", dut.err_count_q, 16'h0);
    #1 rst_n = 1'b1;
    sb_q.delete();
    exp_errcnt = 0;
    step(1'b1, 1'b1, mk(13, 2, 3, 1, 64'h0, 0));
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, idle);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/encode1.md
ENCODE1 -- requirements
Module: encode1

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, width of in_imm.
REQ-002 SHALL have parameter DEPTH, default 4, output FIFO entries (power of two).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  micro-op request present.
REQ-006 in_ready  output  1  request accepted when in_valid & in_ready at clk edge.
REQ-007 in_alu_control  input  6  operation code, table per REQ-012.
REQ-008 in_addressA / in_addressB / in_addressC  input  5 each  rs1 / rs2 / rd.
REQ-009 in_imm  input  BUS_DATA_WIDTH  sign-extended immediate or shift amount.
REQ-010 in_muxB_control  input  1  1 = immediate form, 0 = register form.
REQ-011 out_valid, out_ready (in), out_ins[31:0], out_err  ready/valid instruction stream; out_err qualifies out_ins.

Function
REQ-012 SHALL encode RV64 words: codes 000001-000111 OP-IMM (addi,slti,sltiu,xori,ori,andi,slli); 001000/001001 srli/srai; 001100-010101 OP (add,sub,sll,slt,sltu,xor,srl,sra,or,and); 010110-011001 OP-IMM-32 (addiw,slliw,srliw,sraiw); 011010-011110 OP-32 (addw,subw,sllw,srlw,sraw); 011111-100110 OP funct7=0000001 funct3=000..111 (mul..remu); 100111-101011 OP-32 funct7=0000001 funct3 000,100,101,110,111 (mulw,divw,divuw,remw,remuw).
REQ-013 SHALL place rd=addressC[11:7], rs1=addressA[19:15], rs2=addressB[24:20] (R-type), imm[11:0] into [31:20] (I-type).
REQ-014 SHALL encode 64-bit shift-immediates as funct6 (000000 / 010000) in [31:26], shamt imm[5:0] in [25:20]; W shift-immediates funct7 in [31:25], shamt imm[4:0].
REQ-015 SHALL flag error for: codes 000000, 001010, 001011, >101011; I-type imm[63:11] not all equal; 64-bit shift imm[63:6]!=0; W shift imm[63:5]!=0; in_muxB_control inconsistent with code class.
REQ-016 On error SHALL store out_ins=32'h00000013 with out_err=1; otherwise out_err=0.
REQ-017 Accepted request SHALL be written to FIFO at the accepting edge; out_valid SHALL rise the following cycle (latency 1).
REQ-018 in_ready SHALL equal (count != DEPTH); no push-through when full.
REQ-019 Pop SHALL occur on out_valid & out_ready; out_valid = (count != 0); out_ins/out_err driven from head entry, stable while out_valid & !out_ready.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-021 SHALL keep err_count (16 bit, internal, observable hierarchically) incrementing per accepted erroneous request, saturating at 16'hFFFF.

Reset
REQ-022 rst_n low SHALL asynchronously clear count, pointers, err_count; out_valid=0, in_ready=0 while rst_n low, out_ins=0, out_err=0.
REQ-023 Reset mid-operation SHALL discard all queued entries; first acceptance possible on first edge after rst_n high.

Structure
REQ-024 alu_control code localparams, opcode constants (0010011, 0110011, 0011011, 0111011) and funct fields SHALL reside in shared package riscv_pkg, also imported by decode stage.
REQ-025 Combinational encoding SHALL be sub-module ins_encode (inputs: micro-op; outputs: word, err); FIFO and counters in encode1.

Verification
REQ-026 addi x5,x6,-1 (code 000001, A=6, C=5, imm=all ones, muxB=1) -> out_ins 32'hFFF30293, out_err 0, one cycle after accept.
REQ-027 sub x1,x2,x3 (code 001101, A=2, B=3, C=1, muxB=0) -> 32'h403100B3; mulw x7,x8,x9 (code 100111) -> 32'h029403BB.
REQ-028 srai x10,x10,63 (code 001001, imm=63) -> 32'h43F55513; same with imm=64 -> 32'h00000013, out_err 1, err_count 1.
REQ-029 out_ready=0, 5 requests offered -> 4 accepted, in_ready low; then out_ready=1 with in_valid=1 -> one pop per cycle, count 4 held after in_ready returns, order preserved.
REQ-030 3 entries queued, rst_n pulsed low between edges -> out_valid 0 immediately, err_count 0, next request emerges alone after reset release.
